obstacle_draw: RTL
==================

OBSTACLE_DRAW -- requirements
Module: obstacle_draw

Interface
REQ-001 SHALL have parameter SEG_LEN, default 10: pixels per vertical obstacle; the index range is 0..SEG_LEN-1.
REQ-002 SHALL have parameter OBS_COLOUR, default 3'b100: draw colour.
REQ-003 SHALL have parameter BG_COLOUR, default 3'b000: erase colour.
REQ-004 SHALL have parameter HIT_COLOUR, default 3'b110: draw colour while endgame is high.
REQ-005 SHALL have port clock, input, 1: the single clock.
REQ-006 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: frame tick; one cycle high starts a redraw.
REQ-008 SHALL have port endgame, input, 1: collision flag from the obstacle or snake logic.
REQ-009 SHALL have port obs_x, input, 8: obstacle column for the current v_sel.
REQ-010 SHALL have port obs_y, input, 7: obstacle row for the current v_sel.
REQ-011 SHALL have port v_sel, output, 4: pixel index driven to the obstacle block.
REQ-012 SHALL have port move, output, 1: one-cycle step pulse to the obstacle block.
REQ-013 SHALL have ports plot (output, 1), x_out (output, 8), y_out (output, 7) and colour (output, 3), which together form the VGA write strobe and pixel.
REQ-014 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse when a redraw completes.

Function
REQ-016 SHALL implement the FSM states IDLE, ERASE, MOVE, SETTLE, DRAW, FLUSH, DONE.
REQ-017 SHALL go from IDLE to ERASE when start is sampled high; start SHALL be ignored in every other state.
REQ-018 ERASE SHALL drive v_sel = 0..SEG_LEN-1 on consecutive cycles, then go to MOVE.
REQ-019 MOVE SHALL assert move for exactly one cycle, or not at all when endgame is high, then go to SETTLE.
REQ-020 SETTLE SHALL be one idle cycle that lets the obstacle array update.
REQ-021 SHALL go from SETTLE to DRAW.
REQ-022 DRAW SHALL drive v_sel = 0..SEG_LEN-1 on consecutive cycles, then go to FLUSH.
REQ-023 SHALL go FLUSH -> DONE -> IDLE, one cycle each.
REQ-024 In each ERASE or DRAW cycle, obs_x and obs_y SHALL be sampled, and plot/x_out/y_out/colour SHALL be registered for the next cycle, giving 1-cycle latency.
REQ-025 Colour SHALL be BG_COLOUR for erase pixels, OBS_COLOUR for draw pixels, and HIT_COLOUR for draw pixels when endgame is high.
REQ-026 plot SHALL be low in every cycle that does not follow an ERASE or DRAW cycle.
REQ-027 done SHALL be high only in DONE, which is the cycle after the last plot.
REQ-028 With the default SEG_LEN and start in cycle 0: ERASE SHALL run in cycles 1-10, erase plots in 2-11, move in 11, DRAW in 13-22, draw plots in 14-23, and done in 24.
REQ-029 An endgame change mid-redraw SHALL affect only the pixels sampled after the change.
REQ-030 v_sel SHALL hold 0 outside ERASE and DRAW.
REQ-031 The index counter SHALL be 4 bits, compare against SEG_LEN-1, and never wrap past it.

Reset
REQ-032 resetn low SHALL immediately force state IDLE and set index=0, v_sel=0, move=0, plot=0, x_out=0, y_out=0, colour=BG_COLOUR, busy=0 and done=0.
REQ-033 Reset mid-redraw SHALL abandon the redraw with no further plot or move pulse; the next start SHALL begin a fresh redraw from ERASE.

Configuration
REQ-034 SHALL use the macro OBSTACLE_DRAW_ERASE_EN.
REQ-035 With OBSTACLE_DRAW_ERASE_EN defined, the ERASE pass SHALL be present as specified above.
REQ-036 Without OBSTACLE_DRAW_ERASE_EN, IDLE SHALL go directly to MOVE on start, giving move in cycle 1, draw plots in 4-13 and done in 14, with no BG_COLOUR plots.

Structure
REQ-037 The FSM state encoding, the colour constants and the SEG_LEN default SHALL live in the shared package snake_pkg.
REQ-038 SHALL have no sub-module; the FSM and the output register stage SHALL be a single module.

Verification
REQ-039 SHALL cover: reset, then start with obs_x=40 and obs_y ramping v_sel+5 -> 10 plots (40,5..14) in colour 000, move in cycle 11, 10 plots in colour 100, done in cycle 24.
REQ-040 SHALL cover: endgame=1 before start -> move never asserted, and draw plots use colour 110.
REQ-041 SHALL cover: start pulses in cycles 5 and 15 of an active redraw -> ignored; exactly 20 plots and one done.
REQ-042 SHALL cover: resetn low in cycle 16 -> plot and busy at 0 in the same cycle; a new start gives the full 24-cycle sequence.
REQ-043 SHALL cover: back-to-back start in the cycle after done -> the second redraw is identical; v_sel is 0 in IDLE.
REQ-044 SHALL cover: build without OBSTACLE_DRAW_ERASE_EN -> no 000 plots, move in cycle 1, done in cycle 14.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game drawing blocks.
//   state_t              : obstacle_draw FSM state encoding
//   SEG_LEN_DEFAULT      : default pixels per vertical obstacle
//   *_COLOUR_DEFAULT     : default draw, erase and collision colours
//   is_scan_state()      : true for the states that walk v_sel over the obstacle
package snake_pkg;

    localparam int unsigned SEG_LEN_DEFAULT    = 10;
    localparam logic [2:0]  OBS_COLOUR_DEFAULT = 3'b100;
    localparam logic [2:0]  BG_COLOUR_DEFAULT  = 3'b000;
    localparam logic [2:0]  HIT_COLOUR_DEFAULT = 3'b110;

    typedef enum logic [2:0] {
        StIdle,
        StErase,
        StMove,
        StSettle,
        StDraw,
        StFlush,
        StDone
    } state_t;

    function automatic logic is_scan_state(input state_t s);
        return (s == StErase) || (s == StDraw);
    endfunction

endpackage

// File: rtl/obstacle_draw.sv
// obstacle_draw: redraws one vertical obstacle per frame tick.
// Sequence: [ERASE] -> MOVE -> SETTLE -> DRAW -> FLUSH -> DONE -> IDLE.
// Ports:
//   clock, resetn          : clock and asynchronous active-low reset
//   start                  : frame tick, honoured only in IDLE
//   endgame                : collision flag; suppresses move, selects HIT_COLOUR
//   obs_x, obs_y           : obstacle pixel position for the current v_sel
//   v_sel                  : pixel index to the obstacle block (0 outside scans)
//   move                   : one-cycle step pulse to the obstacle block
//   plot, x_out, y_out,
//   colour                 : registered VGA write strobe and pixel (1-cycle latency)
//   busy, done             : not-idle flag and end-of-redraw pulse
// Build option: define OBSTACLE_DRAW_ERASE_EN to include the ERASE pass; without it
// a start goes straight to MOVE.
module obstacle_draw
    import snake_pkg::*;
#(
    parameter int unsigned SEG_LEN    = SEG_LEN_DEFAULT,  // must not exceed 16
    parameter logic [2:0]  OBS_COLOUR = OBS_COLOUR_DEFAULT,
    parameter logic [2:0]  BG_COLOUR  = BG_COLOUR_DEFAULT,
    parameter logic [2:0]  HIT_COLOUR = HIT_COLOUR_DEFAULT
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       endgame,
    input  logic [7:0] obs_x,
    input  logic [6:0] obs_y,
    output logic [3:0] v_sel,
    output logic       move,
    output logic       plot,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST_IDX = 4'(SEG_LEN - 1);

    state_t     r_state;
    state_t     w_state_d;
    logic [3:0] r_index;
    logic [3:0] w_index_d;
    logic       w_scan;
    logic       w_last;

    logic       r_plot;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_colour;

    assign w_scan = is_scan_state(r_state);
    assign w_last = (r_index == LAST_IDX);

    always_comb begin
        w_state_d = r_state;
        w_index_d = r_index;
        unique case (r_state)
            StIdle: begin
                w_index_d = '0;
                if (start) begin
`ifdef OBSTACLE_DRAW_ERASE_EN
                    w_state_d = StErase;
`else
                    w_state_d = StMove;
`endif
                end
            end
            StErase: begin
                if (w_last) begin
                    w_state_d = StMove;
                    w_index_d = '0;
                end else begin
                    w_index_d = r_index + 4'd1;
                end
            end
            StMove:   w_state_d = StSettle;
            StSettle: w_state_d = StDraw;
            StDraw: begin
                if (w_last) begin
                    w_state_d = StFlush;
                    w_index_d = '0;
                end else begin
                    w_index_d = r_index + 4'd1;
                end
            end
            StFlush:  w_state_d = StDone;
            StDone:   w_state_d = StIdle;
            default: begin
                w_state_d = StIdle;
                w_index_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
            r_index <= '0;
        end else begin
            r_state <= w_state_d;
            r_index <= w_index_d;
        end
    end

    // Pixel stage: whatever obs_x/obs_y show during a scan cycle is written next cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_plot   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= BG_COLOUR;
        end else begin
            r_plot <= w_scan;
            if (w_scan) begin
                r_x <= obs_x;
                r_y <= obs_y;
                if (r_state == StErase) begin
                    r_colour <= BG_COLOUR;
                end else begin
                    r_colour <= endgame ? HIT_COLOUR : OBS_COLOUR;
                end
            end
        end
    end

    // State-decoded outputs; all are inactive in IDLE, which reset forces at once.
    assign v_sel  = w_scan ? r_index : 4'd0;
    assign move   = (r_state == StMove) && !endgame;
    assign busy   = (r_state != StIdle);
    assign done   = (r_state == StDone);
    assign plot   = r_plot;
    assign x_out  = r_x;
    assign y_out  = r_y;
    assign colour = r_colour;

endmodule
